fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with credit-limited memory requests and redirect flush.
// All state advances on the falling clock edge to line up with the CPU pipeline registers.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [15:0] inst_pcplus2,
    input  logic        inst_ready,
    output logic [3:0]  occupancy,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_W = 4'(DEPTH);

    logic [15:0]   fetch_pc;
    logic [1:0]    outstanding;
    logic [1:0]    discard_cnt;
    logic [15:0]   fl_pc [2];
    logic          fl_rd;
    logic          fl_wr;
    logic [15:0]   q_inst [DEPTH];
    logic [15:0]   q_pc [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [3:0]    count;
    logic          resp;
    logic          push;
    logic          pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits cover both queued and in-flight words so a response always has a slot.
    always_comb begin
        imem_req     = !reset && !redirect && outstanding < 2'd2 && (count + {2'b0, outstanding}) < DEPTH_W;
        imem_addr    = fetch_pc;
        inst_valid   = !reset && count != 4'd0;
        occupancy    = reset ? 4'd0 : count;
        inst         = reset ? 16'h0000 : q_inst[head];
        inst_pc      = reset ? 16'h0000 : q_pc[head];
        inst_pcplus2 = reset ? 16'h0000 : q_pc[head] + 16'd2;
        resp         = imem_valid && outstanding != 2'd0;
        push         = resp && discard_cnt == 2'd0 && !redirect;
        pop          = inst_valid && inst_ready && !redirect;
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
            discard_cnt <= 2'd0;
            fl_rd       <= 1'b0;
            fl_wr       <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= 4'd0;
            resp_err    <= 1'b0;
        end else begin
            if (imem_valid && outstanding == 2'd0)
                resp_err <= 1'b1;
            if (resp)
                fl_rd <= !fl_rd;
            if (redirect) begin
                fetch_pc    <= redirect_pc;
                outstanding <= outstanding - {1'b0, resp};
                discard_cnt <= outstanding - {1'b0, resp};
                head        <= '0;
                tail        <= '0;
                count       <= 4'd0;
            end else begin
                if (imem_req) begin
                    fetch_pc     <= fetch_pc + 16'd2;
                    fl_pc[fl_wr] <= fetch_pc;
                    fl_wr        <= !fl_wr;
                end
                outstanding <= outstanding + {1'b0, imem_req} - {1'b0, resp};
                if (resp && discard_cnt != 2'd0)
                    discard_cnt <= discard_cnt - 2'd1;
                if (push) begin
                    q_inst[tail] <= imem_rdata;
                    q_pc[tail]   <= fl_pc[fl_rd];
                    tail         <= nxt(tail);
                end
                if (pop)
                    head <= nxt(head);
                count <= count + {3'b0, push} - {3'b0, pop};
            end
        end
    end
endmodule
